// File: rtl/tcdm_mux_pkg.sv
// Shared TCDM bus constants, mux FSM states and request payload type.
package tcdm_mux_pkg;

  localparam int unsigned TCDM_ADDR_WIDTH = 32;
  localparam int unsigned TCDM_DATA_WIDTH = 32;
  localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } tcdm_mux_state_e;

  typedef struct packed {
    logic [TCDM_ADDR_WIDTH-1:0] add;
    logic                       wen;
    logic [TCDM_DATA_WIDTH-1:0] wdata;
    logic [TCDM_BE_WIDTH-1:0]   be;
  } tcdm_req_t;

  // Index width for n ports; a single port still needs one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_mux_if.sv
// Bundle of the N initiator-side ports and the single target-side port of the TCDM mux.
interface tcdm_mux_if
  import tcdm_mux_pkg::*;
#(
  parameter int unsigned NR_INPUTS = 2
) ();

  // initiator side
  logic [NR_INPUTS-1:0]       in_req_i;
  logic [TCDM_ADDR_WIDTH-1:0] in_add_i     [NR_INPUTS];
  logic [NR_INPUTS-1:0]       in_wen_i;
  logic [TCDM_DATA_WIDTH-1:0] in_wdata_i   [NR_INPUTS];
  logic [TCDM_BE_WIDTH-1:0]   in_be_i      [NR_INPUTS];
  logic [NR_INPUTS-1:0]       in_gnt_o;
  logic [NR_INPUTS-1:0]       in_r_valid_o;
  logic [TCDM_DATA_WIDTH-1:0] in_r_rdata_o [NR_INPUTS];
  logic [NR_INPUTS-1:0]       in_r_opc_o;

  // target side
  logic                       out_req_o;
  logic [TCDM_ADDR_WIDTH-1:0] out_add_o;
  logic                       out_wen_o;
  logic [TCDM_DATA_WIDTH-1:0] out_wdata_o;
  logic [TCDM_BE_WIDTH-1:0]   out_be_o;
  logic                       out_gnt_i;
  logic                       out_r_valid_i;
  logic [TCDM_DATA_WIDTH-1:0] out_r_rdata_i;
  logic                       out_r_opc_i;

  // the mux itself
  modport slave (
    input  in_req_i, in_add_i, in_wen_i, in_wdata_i, in_be_i,
    output in_gnt_o, in_r_valid_o, in_r_rdata_o, in_r_opc_o,
    output out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o,
    input  out_gnt_i, out_r_valid_i, out_r_rdata_i, out_r_opc_i
  );

  // the surrounding masters and shared slave
  modport master (
    output in_req_i, in_add_i, in_wen_i, in_wdata_i, in_be_i,
    input  in_gnt_o, in_r_valid_o, in_r_rdata_o, in_r_opc_o,
    input  out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o,
    output out_gnt_i, out_r_valid_i, out_r_rdata_i, out_r_opc_i
  );

endinterface

// File: rtl/tcdm_mux_rr_picker.sv
// Round-robin pick: lowest requester at or above the pointer, else lowest requester overall.
module tcdm_mux_rr_picker
  import tcdm_mux_pkg::*;
#(
  parameter int unsigned NR_INPUTS = 2,
  parameter int unsigned SEL_WIDTH = sel_width(NR_INPUTS)
) (
  input  logic [NR_INPUTS-1:0] i_req,
  input  logic [SEL_WIDTH-1:0] i_rr_ptr,
  output logic [SEL_WIDTH-1:0] o_idx,
  output logic                 o_valid
);

  logic [NR_INPUTS-1:0] w_masked;
  logic [NR_INPUTS-1:0] w_cand;

  // Drop requesters below the pointer so the search starts there.
  always_comb begin
    w_masked = '0;
    for (int unsigned i = 0; i < NR_INPUTS; i++) begin
      w_masked[i] = i_req[i] && (SEL_WIDTH'(i) >= i_rr_ptr);
    end
  end

  // Priority-encode the masked set, wrapping to the full set when it is empty.
  always_comb begin
    w_cand  = (|w_masked) ? w_masked : i_req;
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = int'(NR_INPUTS) - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        o_idx = SEL_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/tcdm_mux.sv
// N-to-1 TCDM mux: round-robin arbitration, one transaction in flight, response routed to the granted master.
module tcdm_mux
  import tcdm_mux_pkg::*;
#(
  parameter int unsigned NR_INPUTS = 2
) (
  input logic       clk_i,
  input logic       rst_i,
  tcdm_mux_if.slave bus
);

  localparam int unsigned SEL_WIDTH = sel_width(NR_INPUTS);

  tcdm_mux_state_e      r_state;
  logic [SEL_WIDTH-1:0] r_rr_ptr;
  logic [SEL_WIDTH-1:0] r_active;

  logic [SEL_WIDTH-1:0] w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_accept;
  logic                 w_hs;
  logic [SEL_WIDTH-1:0] w_rr_next;
  tcdm_req_t            w_pick_pl;

  tcdm_mux_rr_picker #(
    .NR_INPUTS (NR_INPUTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_picker (
    .i_req    (bus.in_req_i),
    .i_rr_ptr (r_rr_ptr),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // Winner's payload; idle bus is a read of address 0 with no byte enables.
  always_comb begin
    w_pick_pl     = '0;
    w_pick_pl.wen = 1'b1;
    if (w_pick_valid) begin
      w_pick_pl.add   = bus.in_add_i[w_pick_idx];
      w_pick_pl.wen   = bus.in_wen_i[w_pick_idx];
      w_pick_pl.wdata = bus.in_wdata_i[w_pick_idx];
      w_pick_pl.be    = bus.in_be_i[w_pick_idx];
    end
  end

  // Request path: accept in IDLE, or in PENDING on the response cycle for back-to-back issue.
  always_comb begin
    w_accept        = !rst_i && ((r_state == IDLE) || bus.out_r_valid_i);
    bus.out_req_o   = w_accept && w_pick_valid;
    bus.out_add_o   = w_pick_pl.add;
    bus.out_wen_o   = w_pick_pl.wen;
    bus.out_wdata_o = w_pick_pl.wdata;
    bus.out_be_o    = w_pick_pl.be;
    w_hs            = bus.out_req_o && bus.out_gnt_i;
    bus.in_gnt_o    = '0;
    if (w_hs) begin
      bus.in_gnt_o[w_pick_idx] = 1'b1;
    end
    w_rr_next = (w_pick_idx == SEL_WIDTH'(NR_INPUTS - 1)) ? '0 : w_pick_idx + SEL_WIDTH'(1);
  end

  // Response path: forward the slave response to the outstanding master only.
  always_comb begin
    bus.in_r_valid_o = '0;
    bus.in_r_opc_o   = '0;
    for (int unsigned i = 0; i < NR_INPUTS; i++) begin
      bus.in_r_rdata_o[i] = '0;
    end
    if (!rst_i && (r_state == PENDING)) begin
      bus.in_r_valid_o[r_active] = bus.out_r_valid_i;
      bus.in_r_opc_o[r_active]   = bus.out_r_opc_i;
      bus.in_r_rdata_o[r_active] = bus.out_r_rdata_i;
    end
  end

  // FSM, round-robin pointer and outstanding-master index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_active <= '0;
    end else if (w_hs) begin
      r_state  <= PENDING;
      r_active <= w_pick_idx;
      r_rr_ptr <= w_rr_next;
    end else if ((r_state == PENDING) && bus.out_r_valid_i) begin
      r_state <= IDLE;
    end
  end

  // Grants and responses each address at most one master.
  a_gnt_onehot0: assert property (@(posedge clk_i) $onehot0(bus.in_gnt_o));
  a_rvalid_onehot0: assert property (@(posedge clk_i) $onehot0(bus.in_r_valid_o));

  // An ungranted request stays up until the slave takes it.
  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.out_req_o && !bus.out_gnt_i) |=> bus.out_req_o);

  // The slave must not answer while nothing is outstanding.
  a_no_rvalid_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == IDLE) |-> !bus.out_r_valid_i);

endmodule
